// File: rtl/layer_activation_collector_pkg.sv
// Shared types and width helpers for the layer activation collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package layer_activation_collector_pkg;

  // Collector FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Sign-magnitude MAC result width for an n-bit datapath (sign + 3n-4 magnitude bits)
  function automatic int mac_w(input int n);
    return 3 * n - 3;
  endfunction

  // Width needed to hold a count of 0..number_of_neurons inclusive
  function automatic int cnt_w(input int number_of_neurons);
    return $clog2(number_of_neurons + 1);
  endfunction

endpackage

// File: rtl/layer_activation_collector_if.sv
// Bundle of MAC-result input handshake and layer-vector output handshake.
// Latency: n/a (wires only).
// Backpressure: in_ready gates results; out_valid held until out_ack.
interface layer_activation_collector_if
  import layer_activation_collector_pkg::*;
#(
  parameter int n                 = 8,
  parameter int number_of_neurons = 30
);
  localparam int MAC_W = mac_w(n);
  localparam int CNT_W = cnt_w(number_of_neurons);
  localparam int VEC_W = n * number_of_neurons;

  logic             start;
  logic [MAC_W-1:0] mac_result;
  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] layer_out;
  logic             out_valid;
  logic             out_ack;
  logic [CNT_W-1:0] count;

  // Driver of results and consumer of the layer vector
  modport master (
    output start, mac_result, in_valid, out_ack,
    input  in_ready, layer_out, out_valid, count
  );

  // Collector side
  modport slave (
    input  start, mac_result, in_valid, out_ack,
    output in_ready, layer_out, out_valid, count
  );

endinterface

// File: rtl/layer_activation_collector_relu_quantize.sv
// ReLU + right-shift requantisation + saturation to n-bit sign-magnitude.
// Latency: combinational.
// Backpressure: none.
module relu_quantize
  import layer_activation_collector_pkg::*;
#(
  parameter int n     = 8,
  parameter int shift = 7
) (
  input  logic [mac_w(n)-1:0] x_i,
  output logic [n-1:0]        y_o
);
  localparam int MAG_W = mac_w(n) - 1;
  // Largest positive n-bit sign-magnitude value, widened to compare against the shifted magnitude
  localparam logic [MAG_W-1:0] SAT = MAG_W'((1 << (n - 1)) - 1);

  logic             sign;
  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] m;

  assign sign = x_i[MAG_W];
  assign mag  = x_i[MAG_W-1:0];
  assign m    = mag >> shift;

  // Negative inputs and both zeros clamp to +0; large positives saturate
  always_comb begin
    y_o = '0;
    if (!sign && (mag != '0)) begin
      if (m > SAT) begin
        y_o = {1'b0, SAT[n-2:0]};
      end else begin
        y_o = {1'b0, m[n-2:0]};
      end
    end
  end

endmodule

// File: rtl/layer_activation_collector.sv
// Collects one activated MAC result per neuron into a packed layer vector for the next MAC stage.
// Latency: 1 cycle from accepted result to visible slot; out_valid the cycle after the last transfer.
// Backpressure: in_ready only in COLLECT; out_valid held in DONE until out_ack.
module layer_activation_collector
  import layer_activation_collector_pkg::*;
#(
  parameter int n                 = 8,
  parameter int number_of_neurons = 30,
  parameter int shift             = 7
) (
  input logic                      clk,
  input logic                      rst_n,
  layer_activation_collector_if.slave bus
);
  localparam int MAC_W = mac_w(n);
  localparam int CNT_W = cnt_w(number_of_neurons);
  localparam int VEC_W = n * number_of_neurons;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [VEC_W-1:0] layer_q, layer_d;
  logic [n-1:0]     act;

  relu_quantize #(
    .n     (n),
    .shift (shift)
  ) u_relu_quantize (
    .x_i (bus.mac_result),
    .y_o (act)
  );

  // State, count and vector registers; reset abandons any layer in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      layer_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      layer_q <= layer_d;
    end
  end

  // Next-state: start clears and (re)enters COLLECT, transfers fill slot[count], ack releases DONE
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    layer_d = layer_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = COLLECT;
          count_d = '0;
          layer_d = '0;
        end
      end
      COLLECT: begin
        // start wins over a coincident transfer, which is dropped
        if (bus.start) begin
          count_d = '0;
          layer_d = '0;
        end else if (bus.in_valid) begin
          for (int i = 0; i < number_of_neurons; i++) begin
            if (count_q == CNT_W'(i)) begin
              layer_d[n*i +: n] = act;
            end
          end
          count_d = count_q + CNT_W'(1);
          if (count_d == CNT_W'(number_of_neurons)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // start without out_ack is ignored so the held vector cannot be disturbed
        if (bus.out_ack) begin
          if (bus.start) begin
            state_d = COLLECT;
            count_d = '0;
            layer_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.out_valid = (state_q == DONE);
  assign bus.layer_out = layer_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_layer_activation_collector.sv
// Scoreboard bench for layer_activation_collector (n=8, shift=7, 4 neurons).
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: sends wait (bounded) on in_ready.
module tb_layer_activation_collector;
  localparam int N  = 8;
  localparam int NN = 4;
  localparam int SH = 7;
  localparam int MW = 3 * N - 3;
  localparam int CW = $clog2(NN + 1);
  localparam int VW = N * NN;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_activation_collector_if #(.n(N), .number_of_neurons(NN)) bus();

  layer_activation_collector #(
    .n                 (N),
    .number_of_neurons (NN),
    .shift             (SH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] exp_q[$];

  // Reference activation: integer divide by 2^shift, clamp to 127, negatives to 0
  function automatic logic [N-1:0] model_act(input logic [MW-1:0] x);
    int mag;
    int q;
    mag = int'(x[MW-2:0]);
    if (x[MW-1]) return '0;
    q = mag / (1 << SH);
    if (q > 127) q = 127;
    return N'(q);
  endfunction

  // Present one result at a falling edge, wait for in_ready, push its expected slot value
  task automatic send(input logic [MW-1:0] x);
    int g;
    bus.mac_result = x;
    bus.in_valid   = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_in_ready: got %0b want 1", bus.in_ready);
    end
    exp_q.push_back(model_act(x));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.out_ack = 1'b1;
    @(negedge clk);
    bus.out_ack = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.count !== '0 || bus.layer_out !== '0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: count=%0d layer=%h rdy=%0b ov=%0b want 0/0/0/0",
               bus.count, bus.layer_out, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_full_layer();
    logic [N-1:0] e;
    pulse_start();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.count !== CW'(0)) begin
      n_err++;
      $display("FAIL full_start: rdy=%0b count=%0d want 1/0", bus.in_ready, bus.count);
    end
    send(21'd1000);
    send({1'b1, 20'd500});
    send(21'd20000);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.count !== CW'(3)) begin
      n_err++;
      $display("FAIL full_pre_last: ov=%0b count=%0d want 0/3", bus.out_valid, bus.count);
    end
    send(21'd127);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.count !== CW'(4) || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_done: ov=%0b count=%0d rdy=%0b want 1/4/0", bus.out_valid, bus.count, bus.in_ready);
    end
    n_cmp++;
    if (bus.layer_out !== 32'h007F0007) begin
      n_err++;
      $display("FAIL full_vector: got %h want 007f0007", bus.layer_out);
    end
    for (int i = 0; i < NN; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.layer_out[N*i +: N] !== e) begin
        n_err++;
        $display("FAIL full_slot%0d: got %h want %h", i, bus.layer_out[N*i +: N], e);
      end
    end
    pulse_ack();
  endtask

  task automatic test_stalls();
    logic [N-1:0] e;
    logic [VW-1:0] snap;
    logic [MW-1:0] vals[NN];
    vals[0] = 21'd300;
    vals[1] = 21'd40000;
    vals[2] = {1'b1, 20'd9};
    vals[3] = 21'd1280;
    pulse_start();
    for (int k = 0; k < NN; k++) begin
      send(vals[k]);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (bus.count !== CW'(k + 1)) begin
        n_err++;
        $display("FAIL stall_count%0d: got %0d want %0d", k, bus.count, k + 1);
      end
    end
    snap = '0;
    for (int i = 0; i < NN; i++) begin
      e = exp_q.pop_front();
      snap[N*i +: N] = e;
      n_cmp++;
      if (bus.layer_out[N*i +: N] !== e) begin
        n_err++;
        $display("FAIL stall_slot%0d: got %h want %h", i, bus.layer_out[N*i +: N], e);
      end
    end
    // in_valid while DONE must not write anything
    bus.mac_result = 21'd5000;
    bus.in_valid   = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.layer_out !== snap || bus.count !== CW'(4) || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_done_ignore: layer=%h count=%0d rdy=%0b ov=%0b want %h/4/0/1",
               bus.layer_out, bus.count, bus.in_ready, bus.out_valid, snap);
    end
    bus.in_valid = 1'b0;
    pulse_ack();
    // in_valid while IDLE must not write anything either
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.layer_out !== snap || bus.count !== CW'(4) || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_idle_ignore: layer=%h count=%0d rdy=%0b ov=%0b want %h/4/0/0",
               bus.layer_out, bus.count, bus.in_ready, bus.out_valid, snap);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_boundary();
    logic [N-1:0] e;
    pulse_start();
    send(21'd127);
    send(21'd128);
    send(21'd16383);
    send(21'd16384);
    n_cmp++;
    if (bus.layer_out !== 32'h7F7F0100) begin
      n_err++;
      $display("FAIL bound_vec1: got %h want 7f7f0100", bus.layer_out);
    end
    for (int i = 0; i < NN; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.layer_out[N*i +: N] !== e) begin
        n_err++;
        $display("FAIL bound1_slot%0d: got %h want %h", i, bus.layer_out[N*i +: N], e);
      end
    end
    pulse_ack();
    pulse_start();
    send(21'h0FFFFF);
    send({1'b1, 20'd0});
    send(21'd256);
    send({1'b1, 20'hFFFFF});
    n_cmp++;
    if (bus.layer_out !== 32'h0002007F) begin
      n_err++;
      $display("FAIL bound_vec2: got %h want 0002007f", bus.layer_out);
    end
    for (int i = 0; i < NN; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.layer_out[N*i +: N] !== e) begin
        n_err++;
        $display("FAIL bound2_slot%0d: got %h want %h", i, bus.layer_out[N*i +: N], e);
      end
    end
    pulse_ack();
  endtask

  task automatic test_restart();
    logic [N-1:0] e;
    pulse_start();
    send(21'd1000);
    send(21'd2000);
    bus.start      = 1'b1;
    bus.in_valid   = 1'b1;
    bus.mac_result = 21'd3000;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    n_cmp++;
    if (bus.count !== CW'(0) || bus.layer_out !== '0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL restart_clear: count=%0d layer=%h rdy=%0b ov=%0b want 0/0/1/0",
               bus.count, bus.layer_out, bus.in_ready, bus.out_valid);
    end
    send(21'd640);
    send(21'd12800);
    send(21'd0);
    send(21'd1000);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.count !== CW'(4)) begin
      n_err++;
      $display("FAIL restart_done: ov=%0b count=%0d want 1/4", bus.out_valid, bus.count);
    end
    for (int i = 0; i < NN; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.layer_out[N*i +: N] !== e) begin
        n_err++;
        $display("FAIL restart_slot%0d: got %h want %h", i, bus.layer_out[N*i +: N], e);
      end
    end
    pulse_ack();
  endtask

  task automatic test_done_handshake();
    logic [N-1:0] e;
    logic [VW-1:0] snap;
    pulse_start();
    send(21'd384);
    send(21'd1280);
    send(21'd6400);
    send(21'd16256);
    snap = '0;
    for (int i = 0; i < NN; i++) begin
      e = exp_q.pop_front();
      snap[N*i +: N] = e;
    end
    n_cmp++;
    if (bus.layer_out !== snap) begin
      n_err++;
      $display("FAIL hs_vector: got %h want %h", bus.layer_out, snap);
    end
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.count !== CW'(4) || bus.in_ready !== 1'b0 || bus.layer_out !== snap) begin
      n_err++;
      $display("FAIL hs_start_alone: ov=%0b count=%0d rdy=%0b layer=%h want 1/4/0/%h",
               bus.out_valid, bus.count, bus.in_ready, bus.layer_out, snap);
    end
    pulse_ack();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.layer_out !== snap) begin
      n_err++;
      $display("FAIL hs_ack_alone: ov=%0b rdy=%0b layer=%h want 0/0/%h",
               bus.out_valid, bus.in_ready, bus.layer_out, snap);
    end
    pulse_start();
    send(21'd256);
    send(21'd512);
    send(21'd768);
    send(21'd1024);
    for (int i = 0; i < NN; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.layer_out[N*i +: N] !== e) begin
        n_err++;
        $display("FAIL hs_slot%0d: got %h want %h", i, bus.layer_out[N*i +: N], e);
      end
    end
    bus.out_ack = 1'b1;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.out_ack = 1'b0;
    bus.start   = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.count !== CW'(0) || bus.layer_out !== '0) begin
      n_err++;
      $display("FAIL hs_ack_start: rdy=%0b ov=%0b count=%0d layer=%h want 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.count, bus.layer_out);
    end
  endtask

  // Entered in COLLECT with count 0; reset lands between clock edges
  task automatic test_reset_mid();
    send(21'd1000);
    send(21'd2000);
    n_cmp++;
    if (bus.count !== CW'(2) || bus.layer_out !== 32'h00000F07) begin
      n_err++;
      $display("FAIL rstmid_pre: count=%0d layer=%h want 2/00000f07", bus.count, bus.layer_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.count !== '0 || bus.layer_out !== '0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async: count=%0d layer=%h rdy=%0b ov=%0b want 0/0/0/0",
               bus.count, bus.layer_out, bus.in_ready, bus.out_valid);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.count !== '0) begin
      n_err++;
      $display("FAIL rstmid_idle: rdy=%0b ov=%0b count=%0d want 0/0/0", bus.in_ready, bus.out_valid, bus.count);
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.mac_result = '0;
    bus.in_valid   = 1'b0;
    bus.out_ack    = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_full_layer();
    test_stalls();
    test_boundary();
    test_restart();
    test_done_handshake();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
